fir_seq_ctrl: RTL and testbench

Parametrised sequencer for the multi-channel FP16 FIR datapath. It replaces the fixed-period, single-channel controller with an event-driven sequencer. Each accepted input sample starts one filter pass: DMEM write, TAPS multiplies, accumulator pipeline fill, accumulation, normalise, result strobe. It owns per-channel circular DMEM write pointers, drives the shared ALU opcode and enable, and buffers one pending request with overrun detection. It sits between the sample input interface and the DMEM/CMEM/ALU datapath.

---
 rtl/fir_seq_ctrl_if.sv | 44 ++++
 rtl/fir_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_seq_ctrl_if
// Description : Bundle of sample-request and datapath-control signals for the
//               FIR sequencer.
//               master : request source / datapath observer
//                        (drives valid_in, ch_in)
//               slave  : the sequencer
//                        (drives dmem_*, cmem_addr, alu_*, busy, valid_out,
//                         ch_out, overrun)
// Revision    : 1.0  initial release
// ============================================================================
interface fir_seq_ctrl_if #(
  parameter int TAPS = 64,
  parameter int CH   = 1
);
  localparam int AW = $clog2(TAPS);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic              valid_in;
  logic [CW-1:0]     ch_in;
  logic              dmem_wr;
  logic [CW+AW-1:0]  dmem_addr;
  logic [AW-1:0]     cmem_addr;
  logic              alu_en;
  logic [1:0]        alu_opcode;
  logic              busy;
  logic              valid_out;
  logic [CW-1:0]     ch_out;
  logic              overrun;

  modport master (
    output valid_in, ch_in,
    input  dmem_wr, dmem_addr, cmem_addr, alu_en, alu_opcode,
           busy, valid_out, ch_out, overrun
  );

  modport slave (
    input  valid_in, ch_in,
    output dmem_wr, dmem_addr, cmem_addr, alu_en, alu_opcode,
           busy, valid_out, ch_out, overrun
  );
endinterface
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_seq_ctrl
// Description : Event-driven sequencer for the multi-channel FP16 FIR
//               datapath. Each accepted sample runs one filter pass:
//               LOAD (DMEM write), MUL (TAPS multiplies), THRU (adder
//               pipeline fill), ACC (TAPS accumulates), NORM, DONE (result
//               strobe). Keeps per-channel circular DMEM write pointers and a
//               one-entry pending request buffer with overrun detection.
// Ports       : clk_fast - datapath clock, rising edge
//               rst_n    - asynchronous active-low reset
//               bus      - slave side of fir_seq_ctrl_if (request input,
//                          DMEM/CMEM addresses, ALU control, status)
// Revision    : 1.0  initial release
// ============================================================================
module fir_seq_ctrl #(
  parameter int TAPS    = 64,
  parameter int ACC_LAT = 6,
  parameter int CH      = 1
) (
  input  wire logic        clk_fast,
  input  wire logic        rst_n,
  fir_seq_ctrl_if.slave    bus
);
  localparam int AW   = $clog2(TAPS);
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  // Pointer file is sized to the full channel-index range so any ch_in value
  // indexes a real entry.
  localparam int NWP  = 1 << CW;
  localparam int CNTW = $clog2(TAPS + ACC_LAT);

  localparam logic [CNTW-1:0] TAPS_LAST = CNTW'(TAPS - 1);
  localparam logic [CNTW-1:0] THRU_LAST = CNTW'(ACC_LAT - 1);

  localparam logic [1:0] OP_IDLE = 2'b00;  // also ADD29NORM
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  typedef enum logic [6:0] {
    S_IDLE = 7'b000_0001,
    S_LOAD = 7'b000_0010,
    S_MUL  = 7'b000_0100,
    S_THRU = 7'b000_1000,
    S_ACC  = 7'b001_0000,
    S_NORM = 7'b010_0000,
    S_DONE = 7'b100_0000
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic            pend_vld_q, pend_vld_d;
  logic [CW-1:0]   pend_ch_q, pend_ch_d;
  logic            ovr_q, ovr_d;
  logic [AW-1:0]   wp_q [NWP];

  logic [AW-1:0]   wp_cur;
  logic [AW-1:0]   k_idx;
  logic [AW-1:0]   mul_idx;

  assign wp_cur = wp_q[cur_ch_q];
  assign k_idx  = cnt_q[AW-1:0];
  // The pointer has already advanced past the sample written in LOAD, so the
  // newest sample sits at wp-1; walk backwards from there.
  assign mul_idx = wp_cur - AW'(1) - k_idx;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_ch_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_ch_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_ch_q   <= cur_ch_d;
      pend_vld_q <= pend_vld_d;
      pend_ch_q  <= pend_ch_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWP; i++) begin
        wp_q[i] <= '0;
      end
    end else if (state_q == S_LOAD) begin
      wp_q[cur_ch_q] <= wp_cur + AW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_ch_d   = cur_ch_q;
    pend_vld_d = pend_vld_q;
    pend_ch_d  = pend_ch_q;
    ovr_d      = 1'b0;

    // A full buffer drops the new request; DONE consumes requests itself, so
    // only mid-pass requests are parked.
    if (bus.valid_in) begin
      if (pend_vld_q) begin
        ovr_d = 1'b1;
      end else if (state_q != S_IDLE && state_q != S_DONE) begin
        pend_vld_d = 1'b1;
        pend_ch_d  = bus.ch_in;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          cur_ch_d = bus.ch_in;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (cnt_q == TAPS_LAST) begin
          cnt_d   = '0;
          state_d = S_THRU;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_THRU: begin
        if (cnt_q == THRU_LAST) begin
          cnt_d   = '0;
          state_d = S_ACC;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_ACC: begin
        if (cnt_q == TAPS_LAST) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_NORM: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // Buffered request has priority; otherwise chain a coincident request
        // straight into LOAD so back-to-back passes have no IDLE gap.
        if (pend_vld_q) begin
          cur_ch_d   = pend_ch_q;
          pend_vld_d = 1'b0;
          state_d    = S_LOAD;
        end else if (bus.valid_in) begin
          cur_ch_d = bus.ch_in;
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.dmem_wr    = 1'b0;
    bus.dmem_addr  = {cur_ch_q, wp_cur};
    bus.cmem_addr  = '0;
    bus.alu_en     = 1'b0;
    bus.alu_opcode = OP_IDLE;
    bus.busy       = (state_q != S_IDLE);
    bus.valid_out  = 1'b0;
    bus.ch_out     = '0;
    bus.overrun    = ovr_q;

    case (state_q)
      S_LOAD: begin
        bus.dmem_wr = 1'b1;
      end
      S_MUL: begin
        bus.alu_en     = 1'b1;
        bus.alu_opcode = OP_MUL;
        bus.dmem_addr  = {cur_ch_q, mul_idx};
        bus.cmem_addr  = k_idx;
      end
      S_THRU, S_ACC: begin
        bus.alu_en     = 1'b1;
        bus.alu_opcode = OP_ADD;
      end
      S_NORM: begin
        bus.alu_en = 1'b1;
      end
      S_DONE: begin
        bus.valid_out = 1'b1;
        bus.ch_out    = cur_ch_q;
      end
      default: begin
        bus.dmem_wr = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_seq_ctrl
// Description : Directed self-checking bench for fir_seq_ctrl with
//               TAPS=64, ACC_LAT=6, CH=4 (pass length 137 cycles).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fir_seq_ctrl;
  localparam int TAPS    = 64;
  localparam int ACC_LAT = 6;
  localparam int CH      = 4;
  localparam int L       = 2 * TAPS + ACC_LAT + 3;

  logic clk_fast = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #5 clk_fast = ~clk_fast;

  fir_seq_ctrl_if #(.TAPS(TAPS), .CH(CH)) bus ();

  fir_seq_ctrl #(.TAPS(TAPS), .ACC_LAT(ACC_LAT), .CH(CH)) u_dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " dmem_wr"},    0, 32'(bus.dmem_wr),    0);
    chk({tag, " cmem_addr"},  0, 32'(bus.cmem_addr),  0);
    chk({tag, " alu_en"},     0, 32'(bus.alu_en),     0);
    chk({tag, " alu_opcode"}, 0, 32'(bus.alu_opcode), 0);
    chk({tag, " busy"},       0, 32'(bus.busy),       0);
    chk({tag, " valid_out"},  0, 32'(bus.valid_out),  0);
    chk({tag, " ch_out"},     0, 32'(bus.ch_out),     0);
    chk({tag, " overrun"},    0, 32'(bus.overrun),    0);
  endtask

  // Entered at the negedge of the LOAD cycle (cycle 1); returns at the
  // negedge of the DONE cycle. Injects requests at cycles ia/ib (0 = none)
  // and expects the overrun pulse in cycle ovr_c (0 = none).
  task automatic check_pass(input int ch, input int base,
                            input int ia, input int cha,
                            input int ib, input int chb, input int ovr_c);
    int addr, cm, op, en;
    for (int c = 1; c <= L; c++) begin
      cm = 0;
      if (c == 1)                 addr = (ch << 6) | (base & 63);
      else if (c <= TAPS + 1) begin
        addr = (ch << 6) | ((base - (c - 2)) & 63);
        cm   = c - 2;
      end else                    addr = (ch << 6) | ((base + 1) & 63);
      if (c >= 2 && c <= TAPS + 1)            op = 2;
      else if (c > TAPS + 1 && c < L - 1)     op = 3;
      else                                    op = 0;
      en = (c >= 2 && c <= L - 1) ? 1 : 0;
      chk("dmem_wr",    c, 32'(bus.dmem_wr),    (c == 1) ? 1 : 0);
      chk("dmem_addr",  c, 32'(bus.dmem_addr),  addr);
      chk("cmem_addr",  c, 32'(bus.cmem_addr),  cm);
      chk("alu_en",     c, 32'(bus.alu_en),     en);
      chk("alu_opcode", c, 32'(bus.alu_opcode), op);
      chk("busy",       c, 32'(bus.busy),       1);
      chk("valid_out",  c, 32'(bus.valid_out),  (c == L) ? 1 : 0);
      chk("ch_out",     c, 32'(bus.ch_out),     (c == L) ? ch : 0);
      chk("overrun",    c, 32'(bus.overrun),    (c == ovr_c) ? 1 : 0);
      bus.valid_in = (c == ia) || (c == ib);
      bus.ch_in    = (c == ia) ? 2'(cha) : (c == ib) ? 2'(chb) : 2'd0;
      if (c < L) @(negedge clk_fast);
    end
  endtask

  task automatic request(input int ch);
    bus.valid_in = 1'b1;
    bus.ch_in    = 2'(ch);
    @(negedge clk_fast);
    bus.valid_in = 1'b0;
    bus.ch_in    = 2'd0;
  endtask

  task automatic to_idle(input string tag);
    @(negedge clk_fast);
    bus.valid_in = 1'b0;
    bus.ch_in    = 2'd0;
    chk_quiet(tag);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.ch_in    = 2'd0;

    // Reset state
    repeat (3) @(negedge clk_fast);
    chk_quiet("reset");
    chk("reset dmem_addr", 0, 32'(bus.dmem_addr), 0);
    rst_n = 1'b1;
    @(negedge clk_fast);
    chk_quiet("post-reset idle");

    // Single pass on ch0, then 64 chained passes (request coincident with
    // DONE) to walk the ch0 write pointer through its wrap.
    request(0);
    check_pass(0, 0, L, 0, 0, 0, 0);
    for (int n = 1; n <= TAPS; n++) begin
      @(negedge clk_fast);
      check_pass(0, n % TAPS, (n < TAPS) ? L : 0, 0, 0, 0, 0);
    end
    to_idle("after wrap run");

    // ch2 pass with ch3 buffered and ch1 dropped (overrun), then ch3 pass
    // with no IDLE gap, then idle: exactly two result strobes.
    request(2);
    check_pass(2, 0, 10, 3, 20, 1, 21);
    @(negedge clk_fast);
    check_pass(3, 0, 0, 0, 0, 0, 0);
    to_idle("after buffered pass");

    // Both ch2 and ch3 pointers advanced to 1; ch3 chained at DONE.
    request(2);
    check_pass(2, 1, L, 3, 0, 0, 0);
    @(negedge clk_fast);
    check_pass(3, 1, 0, 0, 0, 0, 0);
    to_idle("after pointer check");

    // Reset during MUL at k=30 on ch1.
    request(1);
    repeat (31) @(negedge clk_fast);
    chk("mid-MUL dmem_addr", 32, 32'(bus.dmem_addr), (1 << 6) | 34);
    chk("mid-MUL cmem_addr", 32, 32'(bus.cmem_addr), 30);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("async reset");
    chk("async reset dmem_addr", 0, 32'(bus.dmem_addr), 0);
    repeat (2) @(negedge clk_fast);
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_fast);
      chk("post-abort valid_out", i, 32'(bus.valid_out), 0);
      chk("post-abort busy",      i, 32'(bus.busy),      0);
    end

    // Pointers were cleared: ch0 (previously 1) writes address 0 again.
    request(0);
    check_pass(0, 0, 0, 0, 0, 0, 0);
    to_idle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
